// File: rtl/drum_sequencer.sv
// Drum timing generator for the G-15 memory lines: bit/word-time counters plus a
// command sequencer that produces the word-aligned transfer gate TR.
module drum_sequencer #(
  parameter int unsigned BIT_DIV = 8,
  parameter int unsigned BITS    = 29,
  parameter int unsigned WORDS   = 108
) (
  input  logic       CLOCK,
  input  logic       rst,
  input  logic       ENABLE,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic       CMD_DEFER,
  input  logic [6:0] CMD_T,
  input  logic [6:0] CMD_N,
  output logic       BIT_STB,
  output logic [4:0] DT,
  output logic [6:0] WT,
  output logic       T0,
  output logic       T28,
  output logic [1:0] SECTOR,
  output logic       TR,
  output logic       CMD_DONE,
  output logic       CMD_ERR
);

  localparam int unsigned DivW = $clog2(BIT_DIV);
  localparam logic [DivW-1:0] DivMax = DivW'(BIT_DIV - 1);
  localparam logic [4:0] DtMax = 5'(BITS - 1);
  localparam logic [6:0] WtMax = 7'(WORDS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StAlign,
    StWaitT,
    StXfer,
    StWaitN,
    StErr
  } state_e;

  state_e            r_state;
  logic [DivW-1:0]   r_div;
  logic [4:0]        r_dt;
  logic [6:0]        r_wt;
  logic              r_tr;
  logic              r_done;
  logic              r_err;
  logic [6:0]        r_t;
  logic [6:0]        r_n;
  logic              r_defer;

  logic              w_bit_stb;
  logic              w_boundary;
  logic [6:0]        w_wt_next;
  logic              w_accept;
  logic              w_cmd_bad;
  logic              w_end_xfer;
  logic              w_done_at_end;

  assign w_bit_stb  = ENABLE && (r_div == DivMax);
  assign w_boundary = w_bit_stb && (r_dt == DtMax);
  assign w_wt_next  = (r_wt == WtMax) ? 7'd0 : r_wt + 7'd1;
  assign w_accept   = CMD_VALID && CMD_READY;
  assign w_cmd_bad  = (32'(CMD_T) >= WORDS) || (32'(CMD_N) >= WORDS);
  assign w_end_xfer = r_defer || (w_wt_next == r_t);
  // A deferred command with T==N completes on the boundary that ends its single word.
  assign w_done_at_end = (w_wt_next == r_n) || (r_defer && (r_t == r_n));

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      r_div <= '0;
      r_dt  <= '0;
      r_wt  <= '0;
    end else if (ENABLE) begin
      r_div <= (r_div == DivMax) ? '0 : r_div + 1'b1;
      if (w_bit_stb) begin
        if (r_dt == DtMax) begin
          r_dt <= '0;
          r_wt <= w_wt_next;
        end else begin
          r_dt <= r_dt + 5'd1;
        end
      end
    end
  end

  // Handshake states (Idle/Err) run regardless of ENABLE; drum-timed states only
  // advance on boundaries, which cannot occur while ENABLE is low.
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      r_state <= StIdle;
      r_tr    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_t     <= '0;
      r_n     <= '0;
      r_defer <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_t     <= CMD_T;
            r_n     <= CMD_N;
            r_defer <= CMD_DEFER;
            if (w_cmd_bad) begin
              r_err   <= 1'b1;
              r_state <= StErr;
            end else begin
              r_state <= CMD_DEFER ? StWaitT : StAlign;
            end
          end
        end
        StErr: r_state <= StIdle;
        StAlign: begin
          if (w_boundary) begin
            r_tr    <= 1'b1;
            r_state <= StXfer;
          end
        end
        StWaitT: begin
          if (w_boundary && (w_wt_next == r_t)) begin
            r_tr    <= 1'b1;
            r_state <= StXfer;
          end
        end
        StXfer: begin
          if (w_boundary && w_end_xfer) begin
            r_tr <= 1'b0;
            if (w_done_at_end) begin
              r_done  <= 1'b1;
              r_state <= StIdle;
            end else begin
              r_state <= StWaitN;
            end
          end
        end
        StWaitN: begin
          if (w_boundary && (w_wt_next == r_n)) begin
            r_done  <= 1'b1;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign CMD_READY = !rst && (r_state == StIdle);
  assign BIT_STB   = w_bit_stb;
  assign DT        = r_dt;
  assign WT        = r_wt;
  assign T0        = (r_dt == 5'd0);
  assign T28       = (r_dt == DtMax);
  assign SECTOR    = r_wt[1:0];
  assign TR        = r_tr;
  assign CMD_DONE  = r_done;
  assign CMD_ERR   = r_err;

endmodule

// File: tb/tb_drum_sequencer.sv
// Directed self-checking bench for drum_sequencer with BIT_DIV=2 (58 cycles per word).
module tb_drum_sequencer;

  logic       CLOCK = 1'b0;
  logic       rst;
  logic       ENABLE;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic       CMD_DEFER;
  logic [6:0] CMD_T;
  logic [6:0] CMD_N;
  logic       BIT_STB;
  logic [4:0] DT;
  logic [6:0] WT;
  logic       T0;
  logic       T28;
  logic [1:0] SECTOR;
  logic       TR;
  logic       CMD_DONE;
  logic       CMD_ERR;

  int checks = 0;
  int errors = 0;

  always #5 CLOCK = ~CLOCK;

  drum_sequencer #(.BIT_DIV(2), .BITS(29), .WORDS(108)) dut (
    .CLOCK(CLOCK), .rst(rst), .ENABLE(ENABLE), .CMD_VALID(CMD_VALID),
    .CMD_READY(CMD_READY), .CMD_DEFER(CMD_DEFER), .CMD_T(CMD_T), .CMD_N(CMD_N),
    .BIT_STB(BIT_STB), .DT(DT), .WT(WT), .T0(T0), .T28(T28), .SECTOR(SECTOR),
    .TR(TR), .CMD_DONE(CMD_DONE), .CMD_ERR(CMD_ERR)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_wt(input int v);
    int n = 0;
    while (int'(WT) != v && n < 14000) begin
      step();
      n++;
    end
    check($sformatf("wait_wt_%0d", v), 32'(WT), 32'(v));
  endtask

  task automatic issue(input logic d, input int t, input int n);
    CMD_DEFER = d;
    CMD_T     = 7'(t);
    CMD_N     = 7'(n);
    CMD_VALID = 1'b1;
    check("issue_ready", 32'(CMD_READY), 1);
    step();
    CMD_VALID = 1'b0;
    check("ready_drop", 32'(CMD_READY), 0);
  endtask

  // Watch one command through to CMD_DONE; optionally freeze ENABLE for 10 cycles
  // once TR has been high for drop_after cycles.
  task automatic run_xfer(input string tag, input int drop_after, input int exp_cycles,
                          input int exp_first, input int exp_last, input int exp_done_wt);
    int   trc = 0;
    int   first = -1;
    int   last = -1;
    int   rises = 0;
    int   bad_align = 0;
    int   errs = 0;
    int   n = 0;
    int   dwt = -1;
    int   ddt = -1;
    int   drdy = -1;
    int   wsave;
    int   dsave;
    logic prev_tr;
    logic seen = 1'b0;
    logic dropped = 1'b0;
    prev_tr = TR;
    while (!seen && n < 8000) begin
      step();
      n++;
      if (TR !== prev_tr) begin
        if (!(DT == 5'd0 && !BIT_STB)) bad_align++;
        if (TR) rises++;
      end
      prev_tr = TR;
      if (CMD_ERR) errs++;
      if (TR) begin
        trc++;
        if (first < 0) first = int'(WT);
        last = int'(WT);
      end
      if (CMD_DONE) begin
        seen = 1'b1;
        dwt  = int'(WT);
        ddt  = int'(DT);
        drdy = int'(CMD_READY);
      end
      if (drop_after >= 0 && !dropped && TR && trc == drop_after) begin
        dropped = 1'b1;
        wsave = int'(WT);
        dsave = int'(DT);
        ENABLE = 1'b0;
        for (int i = 0; i < 10; i++) begin
          step();
          if (TR) trc++;
        end
        check({tag, "_hold_wt"}, 32'(WT), 32'(wsave));
        check({tag, "_hold_dt"}, 32'(DT), 32'(dsave));
        check({tag, "_hold_tr"}, 32'(TR), 1);
        ENABLE = 1'b1;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 1);
    check({tag, "_tr_cycles"}, 32'(trc), 32'(exp_cycles));
    check({tag, "_first_wt"}, 32'(first), 32'(exp_first));
    check({tag, "_last_wt"}, 32'(last), 32'(exp_last));
    check({tag, "_tr_rises"}, 32'(rises), 1);
    check({tag, "_tr_align"}, 32'(bad_align), 0);
    check({tag, "_no_err"}, 32'(errs), 0);
    check({tag, "_done_wt"}, 32'(dwt), 32'(exp_done_wt));
    check({tag, "_done_dt"}, 32'(ddt), 0);
    check({tag, "_done_ready"}, 32'(drdy), 1);
    step();
    check({tag, "_done_pulse"}, 32'(CMD_DONE), 0);
  endtask

  initial begin
    int bad_dt = 0;
    int bad_wt = 0;
    int bad_stb = 0;
    int bad_sec = 0;
    int bad_t = 0;
    int stb_cnt = 0;
    int n_done = 0;
    int n_tr = 0;
    int n = 0;
    logic saw107 = 1'b0;

    rst = 1'b1;
    ENABLE = 1'b1;
    CMD_VALID = 1'b0;
    CMD_DEFER = 1'b0;
    CMD_T = '0;
    CMD_N = '0;
    step();
    step();
    check("rst_dt", 32'(DT), 0);
    check("rst_wt", 32'(WT), 0);
    check("rst_t0", 32'(T0), 1);
    check("rst_t28", 32'(T28), 0);
    check("rst_sector", 32'(SECTOR), 0);
    check("rst_tr", 32'(TR), 0);
    check("rst_stb", 32'(BIT_STB), 0);
    check("rst_done", 32'(CMD_DONE), 0);
    check("rst_err", 32'(CMD_ERR), 0);
    check("rst_ready", 32'(CMD_READY), 0);

    // Free run over one full revolution; n counts enabled edges since release.
    rst = 1'b0;
    for (int k = 1; k <= 2 * 29 * 108; k++) begin
      step();
      if (k == 1) check("ready_after_rst", 32'(CMD_READY), 1);
      if (BIT_STB !== ((k % 2) == 1)) bad_stb++;
      if (int'(DT) != (k / 2) % 29) bad_dt++;
      if (int'(WT) != (k / 58) % 108) bad_wt++;
      if (int'(SECTOR) != ((k / 58) % 108) % 4) bad_sec++;
      if (T0 !== (((k / 2) % 29) == 0) || T28 !== (((k / 2) % 29) == 28)) bad_t++;
      if (BIT_STB) stb_cnt++;
      if (WT == 7'd107) saw107 = 1'b1;
    end
    check("run_stb", 32'(bad_stb), 0);
    check("run_dt", 32'(bad_dt), 0);
    check("run_wt", 32'(bad_wt), 0);
    check("run_sector", 32'(bad_sec), 0);
    check("run_t0_t28", 32'(bad_t), 0);
    check("run_stb_count", 32'(stb_cnt), 3132);
    check("run_saw_107", 32'(saw107), 1);
    check("run_wrap_wt", 32'(WT), 0);

    wait_wt(2);
    issue(1'b1, 5, 9);
    run_xfer("defer", -1, 58, 5, 5, 9);

    wait_wt(17);
    issue(1'b1, 20, 20);
    run_xfer("defer_t_eq_n", -1, 58, 20, 20, 21);

    wait_wt(30);
    issue(1'b0, 33, 34);
    run_xfer("enable_hold", 20, 126, 31, 32, 34);

    issue(1'b0, 108, 0);
    check("err_t_pulse", 32'(CMD_ERR), 1);
    check("err_t_tr", 32'(TR), 0);
    step();
    check("err_t_clear", 32'(CMD_ERR), 0);
    check("err_t_ready", 32'(CMD_READY), 1);
    issue(1'b1, 3, 127);
    check("err_n_pulse", 32'(CMD_ERR), 1);
    step();
    check("err_n_ready", 32'(CMD_READY), 1);
    check("err_n_tr", 32'(TR), 0);
    check("err_n_done", 32'(CMD_DONE), 0);

    wait_wt(105);
    issue(1'b0, 1, 2);
    run_xfer("imm_wrap", -1, 174, 106, 0, 2);

    wait_wt(3);
    issue(1'b0, 10, 12);
    run_xfer("imm", -1, 348, 4, 9, 12);

    wait_wt(3);
    issue(1'b0, 4, 4);
    run_xfer("imm_full_rev", -1, 6264, 4, 3, 4);

    wait_wt(40);
    issue(1'b0, 45, 46);
    while (!TR && n < 200) begin
      step();
      n++;
    end
    check("rst_mid_tr_started", 32'(TR), 1);
    for (int i = 0; i < 30; i++) step();
    rst = 1'b1;
    step();
    check("rst_mid_tr", 32'(TR), 0);
    check("rst_mid_ready_low", 32'(CMD_READY), 0);
    check("rst_mid_wt", 32'(WT), 0);
    rst = 1'b0;
    #1;
    check("rst_mid_ready", 32'(CMD_READY), 1);
    for (int i = 0; i < 50 * 58; i++) begin
      step();
      if (CMD_DONE) n_done++;
      if (TR) n_tr++;
    end
    check("rst_mid_no_done", 32'(n_done), 0);
    check("rst_mid_no_tr", 32'(n_tr), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
